// File: rtl/trng_pkg.sv
// trng_pkg: shared types and constants for the gated-ring-oscillator TRNG controller.
//   state_t    controller state encoding
//   VN_PAIR_*  raw sample pairs {first, second} that produce a packed bit when
//              the VON_NEUMANN_EN build option is defined
package trng_pkg;

  typedef enum logic [2:0] {IDLE, WARMUP, COLLECT, OUTPUT, ERROR} state_t;

  // Von Neumann debiasing: 01 packs 0, 10 packs 1; 00 and 11 are dropped.
  localparam logic [1:0] VN_PAIR_0 = 2'b01;
  localparam logic [1:0] VN_PAIR_1 = 2'b10;

endpackage

// File: rtl/trng_if.sv
// trng_if: random word valid/ready channel.
//   rnd_data   random word, first-sampled bit in the MSB
//   rnd_valid  rnd_data holds a complete word
//   rnd_ready  consumer accepts the word when rnd_valid & rnd_ready
// modport master = word producer (controller), slave = consumer.
interface trng_if #(parameter int WIDTH = 32) ();
  logic [WIDTH-1:0] rnd_data;
  logic             rnd_valid;
  logic             rnd_ready;

  modport master (output rnd_data, output rnd_valid, input rnd_ready);
  modport slave  (input rnd_data, input rnd_valid, output rnd_ready);
endinterface

// File: rtl/trng_rep_test.sv
// trng_rep_test: repetition-count health test on raw oscillator samples.
//   clk, reset    clock, synchronous active-high reset
//   clear         restarts the run counter (held while the controller is idle)
//   sample        raw sample value
//   sample_valid  sample is taken this cycle
//   fail          combinational pulse: this sample makes the run reach REP_LIMIT
module trng_rep_test #(
  parameter int REP_LIMIT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic sample,
  input  logic sample_valid,
  output logic fail
);

  localparam int CW = $clog2(REP_LIMIT + 1);

  logic [CW-1:0] cnt, cnt_nx;
  logic          last;

  // Run length restarts at 1 on a changed sample (or the first one after clear);
  // saturates at the limit so it can never wrap.
  always_comb begin
    cnt_nx = CW'(1);
    if (cnt != '0 && sample == last)
      cnt_nx = (cnt == CW'(REP_LIMIT)) ? cnt : cnt + CW'(1);
  end

  assign fail = sample_valid && (cnt_nx == CW'(REP_LIMIT));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt  <= '0;
      last <= 1'b0;
    end else if (sample_valid) begin
      cnt  <= cnt_nx;
      last <= sample;
    end
  end

endmodule

// File: rtl/trng_controller.sv
// trng_controller: sequences one gated-ring-oscillator entropy source.
// Powers the oscillator, waits WARMUP_CYCLES, takes a raw sample every
// SAMPLE_DIV cycles, runs a repetition-count health test and packs WIDTH
// bits (first bit ends in the MSB) into a word offered on a valid/ready channel.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   enable        level: 1 = produce words, 0 = return to idle
//   garo_bit      oscillator output, already synchronous to clk
//   garo_reset    oscillator run control, active-low (0 = stopped)
//   rnd           trng_if master: rnd_data / rnd_valid / rnd_ready
//   health_fail   sticky repetition-count failure
//   err_clr       clears health_fail (only acts after a failure)
//   busy          controller not idle
// Build option: VON_NEUMANN_EN packs debiased bits from raw sample pairs
// instead of every raw sample.
module trng_controller
  import trng_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int WARMUP_CYCLES = 64,
  parameter int SAMPLE_DIV    = 4,
  parameter int REP_LIMIT     = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          garo_bit,
  output logic          garo_reset,
  trng_if.master        rnd,
  output logic          health_fail,
  input  logic          err_clr,
  output logic          busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  localparam int DW = $clog2(SAMPLE_DIV + 1);

  state_t           state, state_nx;
  logic [WW-1:0]    wcnt;
  logic [DW-1:0]    dcnt;
  logic [BW-1:0]    bcnt;
  logic [WIDTH-1:0] data;

  logic div_last, warm_done, raw_vld, raw_ok, rep_fail;
  logic pk_vld, pk_bit, word_done;

  assign div_last  = dcnt == DW'(SAMPLE_DIV - 1);
  assign warm_done = wcnt == WW'(WARMUP_CYCLES - 1);
  assign raw_vld   = (state == COLLECT) && div_last;
  // A sample that trips the health test is never packed.
  assign raw_ok    = raw_vld && !rep_fail;
  assign word_done = pk_vld && (bcnt == BW'(WIDTH - 1));

  // Run counter is held clear while idle, so every warm-up starts a fresh run.
  trng_rep_test #(.REP_LIMIT(REP_LIMIT)) u_rep (
    .clk          (clk),
    .reset        (reset),
    .clear        (state == IDLE),
    .sample       (garo_bit),
    .sample_valid (raw_vld),
    .fail         (rep_fail)
  );

`ifdef VON_NEUMANN_EN
  logic word_clr, pair_full, pair_a;

  // Pair register follows the bit counter: cleared in idle and on handshake.
  assign word_clr = (state == IDLE) || (state == OUTPUT && rnd.rnd_ready);

  always_ff @(posedge clk) begin
    if (reset || word_clr) begin
      pair_full <= 1'b0;
      pair_a    <= 1'b0;
    end else if (raw_ok) begin
      pair_full <= !pair_full;
      pair_a    <= garo_bit;
    end
  end

  assign pk_vld = raw_ok && pair_full && ({pair_a, garo_bit} inside {VN_PAIR_0, VN_PAIR_1});
  assign pk_bit = pair_a;
`else
  assign pk_vld = raw_ok;
  assign pk_bit = garo_bit;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Health failure outranks both enable drop and word completion.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = WARMUP;
      WARMUP:  if (!enable) state_nx = IDLE;
               else if (warm_done) state_nx = COLLECT;
      COLLECT: if (rep_fail) state_nx = ERROR;
               else if (!enable) state_nx = IDLE;
               else if (word_done) state_nx = OUTPUT;
      OUTPUT:  if (rnd.rnd_ready) state_nx = enable ? COLLECT : IDLE;
      ERROR:   if (err_clr) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt <= '0;
      dcnt <= '0;
      bcnt <= '0;
      data <= '0;
    end else begin
      case (state)
        // Idle discards any partial word and zeroes every counter.
        IDLE: begin
          wcnt <= '0;
          dcnt <= '0;
          bcnt <= '0;
          data <= '0;
        end
        WARMUP: wcnt <= wcnt + WW'(1);
        COLLECT: begin
          dcnt <= div_last ? '0 : dcnt + DW'(1);
          if (pk_vld) begin
            data <= {data[WIDTH-2:0], pk_bit};
            bcnt <= bcnt + BW'(1);
          end
        end
        // Sampling paused while the word waits; restart the grid on handshake.
        OUTPUT: if (rnd.rnd_ready) begin
          bcnt <= '0;
          dcnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs are flops decoded from the next state, so they track state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      garo_reset    <= 1'b0;
      rnd.rnd_valid <= 1'b0;
      health_fail   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      garo_reset    <= state_nx inside {WARMUP, COLLECT, OUTPUT};
      rnd.rnd_valid <= state_nx == OUTPUT;
      health_fail   <= state_nx == ERROR;
      busy          <= state_nx != IDLE;
    end
  end

  assign rnd.rnd_data = data;

endmodule

// File: tb/tb_trng_controller.sv
// tb_trng_controller: randomized self-checking bench for trng_controller.
// The reference model works per raw sample: raw sample n after the start of
// collection is the garo_bit value present at edge start + n*SAMPLE_DIV. It
// tracks the run length of identical samples, packs bits (optionally Von
// Neumann pairs) into a queue and predicts the word and the cycle it appears.
module tb_trng_controller;

  localparam int WIDTH = 32;
  localparam int WARM  = 64;
  localparam int DIV   = 4;
  localparam int REP   = 32;

  logic clk = 1'b0;
  logic reset, enable, garo_bit, err_clr;
  logic garo_reset, health_fail, busy;

  trng_if #(.WIDTH(WIDTH)) rnd ();

  trng_controller #(
    .WIDTH(WIDTH), .WARMUP_CYCLES(WARM), .SAMPLE_DIV(DIV), .REP_LIMIT(REP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .garo_bit    (garo_bit),
    .garo_reset  (garo_reset),
    .rnd         (rnd),
    .health_fail (health_fail),
    .err_clr     (err_clr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // reference model state
  int               run_len;
  bit               run_val;
  bit               pq[$];
  bit               vn_have, vn_a;
  logic [WIDTH-1:0] exp_word;
  // run-shaped stimulus state
  int               rl;
  bit               rv;
  int               res;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear_word();
    pq.delete();
    vn_have = 1'b0;
  endtask

  task automatic model_new_session();
    run_len = 0;
    model_clear_word();
  endtask

  // Returns 1 when this raw sample reaches the repetition limit.
  function automatic bit model_sample(input bit raw);
    run_len = (run_len > 0 && raw == run_val) ? run_len + 1 : 1;
    run_val = raw;
    if (run_len >= REP) return 1'b1;
`ifdef VON_NEUMANN_EN
    if (!vn_have) begin
      vn_a    = raw;
      vn_have = 1'b1;
    end else begin
      vn_have = 1'b0;
      if (vn_a != raw) pq.push_back(vn_a);
    end
`else
    pq.push_back(raw);
`endif
    return 1'b0;
  endfunction

  // Starts from the edge that entered COLLECT. mode: 0 random, 1 alternating
  // 1,0,..., 2 stuck 0, 3 runs just under the limit.
  // res: 1 health failure, 2 word delivered, 3 stop_after bits packed.
  task automatic collect_word(input int mode, input int stop_after, output int r);
    bit raw;
    int n;
    n = 0;
    r = 0;
    rl = 0;
    rv = run_val;
    for (int g = 0; g < 6000 && r == 0; g++) begin
      for (int k = 1; k <= DIV; k++) begin
        raw = 1'($urandom_range(0, 1));
        if (k == DIV) begin
          case (mode)
            1: raw = ~n[0];
            2: raw = 1'b0;
            3: begin
              if (rl == 0) begin
                rv = ~rv;
                rl = $urandom_range(REP - 1, REP - 4);
              end
              raw = rv;
              rl--;
            end
            default: ;
          endcase
        end
        garo_bit      = raw;
        err_clr       = 1'($urandom_range(0, 1));
        rnd.rnd_ready = 1'($urandom_range(0, 1));
        tick();
      end
      n++;
      if (model_sample(raw)) begin
        chk("fail_flag", health_fail, 1);
        chk("fail_garo_reset", garo_reset, 0);
        chk("fail_valid", rnd.rnd_valid, 0);
        r = 1;
      end else if (pq.size() == WIDTH) begin
        exp_word = '0;
        foreach (pq[i]) exp_word = (exp_word << 1) | WIDTH'(pq[i]);
        chk("word_valid", rnd.rnd_valid, 1);
        chk("word_data", rnd.rnd_data, exp_word);
        r = 2;
      end else begin
        chk("collect_valid", rnd.rnd_valid, 0);
        if (pq.size() == stop_after) r = 3;
      end
    end
    if (r == 0) chk("collect_timeout", r, 2);
    err_clr       = 1'b0;
    rnd.rnd_ready = 1'b0;
  endtask

  task automatic start_session();
    enable = 1'b1;
    tick();
    chk("warm_garo_reset", garo_reset, 1);
    chk("warm_busy", busy, 1);
    repeat (WARM) begin
      garo_bit = 1'($urandom_range(0, 1));
      err_clr  = 1'($urandom_range(0, 1));
      tick();
    end
    err_clr = 1'b0;
    chk("warm_valid", rnd.rnd_valid, 0);
    model_new_session();
  endtask

  task automatic handshake(input bit en);
    enable        = en;
    rnd.rnd_ready = 1'b1;
    tick();
    chk("hs_valid_drop", rnd.rnd_valid, 0);
    chk("hs_busy", busy, en);
    rnd.rnd_ready = 1'b0;
    model_clear_word();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; garo_bit = 1'b0; err_clr = 1'b0;
    rnd.rnd_ready = 1'b0;
    run_val = 1'b0;
    repeat (3) tick();
    chk("rst_valid", rnd.rnd_valid, 0);
    chk("rst_data", rnd.rnd_data, 0);
    chk("rst_fail", health_fail, 0);
    chk("rst_garo_reset", garo_reset, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // alternating samples after a full warm-up
    start_session();
    collect_word(1, -1, res);
    chk("alt_res", res, 2);
`ifndef VON_NEUMANN_EN
    chk("alt_word", rnd.rnd_data, 32'hAAAA_AAAA);
`endif

    // backpressure: word held while enable wiggles and garo_bit toggles
    for (int i = 0; i < 10; i++) begin
      enable   = 1'($urandom_range(0, 1));
      garo_bit = ~garo_bit;
      tick();
      chk("hold_valid", rnd.rnd_valid, 1);
      chk("hold_data", rnd.rnd_data, exp_word);
    end
    handshake(1'b1);
    collect_word(0, -1, res);
    chk("bp_next_res", res, 2);

    // back-to-back words, the last one with runs just under the limit
    for (int w = 0; w < 3; w++) begin
      repeat ($urandom_range(0, 3)) begin
        tick();
        chk("wait_valid", rnd.rnd_valid, 1);
      end
      handshake(1'b1);
      collect_word((w == 2) ? 3 : 0, -1, res);
      chk("loop_res", res, 2);
    end
    handshake(1'b0);

    // enable dropped mid-word, and during warm-up
    start_session();
    collect_word(0, 10, res);
    chk("partial_res", res, 3);
    enable = 1'b0;
    tick();
    chk("drop_busy", busy, 0);
    chk("drop_garo_reset", garo_reset, 0);
    enable = 1'b1;
    tick();
    chk("rewarm_busy", busy, 1);
    repeat (5) tick();
    enable = 1'b0;
    tick();
    chk("warm_drop_busy", busy, 0);
    start_session();
    collect_word(0, -1, res);
    chk("fresh_res", res, 2);

    // reset while a word is offered
    tick();
    reset = 1'b1;
    tick();
    chk("rst2_valid", rnd.rnd_valid, 0);
    chk("rst2_data", rnd.rnd_data, 0);
    chk("rst2_garo_reset", garo_reset, 0);
    chk("rst2_busy", busy, 0);
    reset = 1'b0;

    // stuck oscillator: failure, sticky error, clear, restart
    start_session();
    collect_word(2, -1, res);
    chk("stuck_res", res, 1);
    repeat (5) begin
      garo_bit = 1'($urandom_range(0, 1));
      tick();
      chk("err_hold_fail", health_fail, 1);
      chk("err_hold_valid", rnd.rnd_valid, 0);
      chk("err_hold_garo_reset", garo_reset, 0);
    end
    err_clr = 1'b1;
    tick();
    chk("clr_fail", health_fail, 0);
    chk("clr_busy", busy, 0);
    err_clr = 1'b0;
    start_session();
    collect_word(0, -1, res);
    chk("after_err_res", res, 2);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
